// File: rtl/noc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | noc_pkg : flit format constants and helpers for the ring-NoC NI     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package noc_pkg;

  localparam int FLIT_W   = 8;
  localparam int DATA_W   = 6;
  localparam int NODE_W   = 2;
  localparam int TYPE_MSB = 7;
  localparam int TYPE_LSB = 6;
  localparam int DEST_MSB = 5;
  localparam int DEST_LSB = 4;
  localparam int SRC_MSB  = 3;
  localparam int SRC_LSB  = 2;

  typedef enum logic [1:0] {
    FT_IDLE = 2'b00,
    FT_HEAD = 2'b01,
    FT_BODY = 2'b10,
    FT_TAIL = 2'b11
  } flit_type_e;

  function automatic logic [FLIT_W-1:0] make_head(input logic [NODE_W-1:0] dest,
                                                  input logic [NODE_W-1:0] src);
    return {FT_HEAD, dest, src, 2'b00};
  endfunction

  function automatic logic [FLIT_W-1:0] make_data(input flit_type_e t,
                                                  input logic [DATA_W-1:0] d);
    return {t, d};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ni_rx_assembler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ni_rx_assembler : checks ejected flits and rebuilds core messages   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module ni_rx_assembler
  import noc_pkg::*;
#(
  parameter int PAYLOAD_FLITS = 2,
  localparam int PW = DATA_W * PAYLOAD_FLITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NODE_W-1:0] node_i,
  input  logic [FLIT_W-1:0] flit_i,
  input  logic              en_i,
  output logic              valid_o,
  output logic [NODE_W-1:0] src_o,
  output logic [PW-1:0]     payload_o,
  output logic              err_o
);

  localparam int            CW       = $clog2(PAYLOAD_FLITS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(PAYLOAD_FLITS - 1);

  localparam logic [0:0] RX_IDLE = 1'b0;
  localparam logic [0:0] RX_DATA = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     shreg_q, shreg_d;
  logic [NODE_W-1:0] cur_src_q, cur_src_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [NODE_W-1:0] src_q, src_d;
  logic [PW-1:0]     pay_q, pay_d;

  flit_type_e    w_type;
  logic [PW-1:0] w_shifted;

  assign w_type    = flit_type_e'(flit_i[TYPE_MSB:TYPE_LSB]);
  assign w_shifted = PW'({shreg_q, flit_i[DATA_W-1:0]});

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    cur_src_d = cur_src_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    src_d     = src_q;
    pay_d     = pay_q;
    if (en_i && (w_type != FT_IDLE)) begin
      case (w_type)
        FT_HEAD: begin
          // A head arriving mid-packet aborts it but still opens a new packet.
          if (state_q == RX_DATA) err_d = 1'b1;
          if (flit_i[DEST_MSB:DEST_LSB] == node_i) begin
            state_d   = RX_DATA;
            cur_src_d = flit_i[SRC_MSB:SRC_LSB];
            cnt_d     = '0;
            shreg_d   = '0;
          end else begin
            err_d   = 1'b1;
            state_d = RX_IDLE;
          end
        end
        FT_BODY: begin
          if ((state_q == RX_IDLE) || (cnt_q == LAST_IDX)) begin
            err_d   = 1'b1;
            state_d = RX_IDLE;
          end else begin
            shreg_d = w_shifted;
            cnt_d   = cnt_q + CW'(1);
          end
        end
        default: begin
          if ((state_q == RX_DATA) && (cnt_q == LAST_IDX)) begin
            valid_d = 1'b1;
            src_d   = cur_src_q;
            pay_d   = w_shifted;
          end else begin
            err_d = 1'b1;
          end
          state_d = RX_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      cur_src_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      src_q     <= '0;
      pay_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      cur_src_q <= cur_src_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      src_q     <= src_d;
      pay_q     <= pay_d;
    end
  end

  assign valid_o   = valid_q;
  assign err_o     = err_q;
  assign src_o     = src_q;
  assign payload_o = pay_q;

endmodule
`default_nettype wire

// File: rtl/noc_network_interface.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | noc_network_interface : core <-> ring-router packetizer/reassembler |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module noc_network_interface
  import noc_pkg::*;
#(
  parameter int PAYLOAD_FLITS = 2,
  localparam int PW = DATA_W * PAYLOAD_FLITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NODE_W-1:0] current_node,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [NODE_W-1:0] tx_dest,
  input  logic [PW-1:0]     tx_payload,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_valid,
  input  logic              noc_ready,
  input  logic [FLIT_W-1:0] flit_in,
  input  logic              flit_in_en,
  output logic              rx_valid,
  output logic [NODE_W-1:0] rx_src,
  output logic [PW-1:0]     rx_payload,
  output logic              rx_err
);

  localparam int            CW       = $clog2(PAYLOAD_FLITS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(PAYLOAD_FLITS - 1);

  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_HEAD = 2'd1;
  localparam logic [1:0] TX_DATA = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [NODE_W-1:0] dest_q, dest_d;
  logic [NODE_W-1:0] src_q, src_d;
  logic [PW-1:0]     pay_q, pay_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic       w_hs;
  flit_type_e w_dtype;

  assign w_hs       = flit_valid && noc_ready;
  assign flit_valid = (state_q != TX_IDLE);
  assign tx_ready   = (state_q == TX_IDLE) && !rst;

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    src_d   = src_q;
    pay_d   = pay_q;
    cnt_d   = cnt_q;
    case (state_q)
      TX_IDLE: begin
        if (tx_valid) begin
          dest_d  = tx_dest;
          src_d   = current_node;
          pay_d   = tx_payload;
          cnt_d   = '0;
          state_d = TX_HEAD;
        end
      end
      TX_HEAD: begin
        if (w_hs) state_d = TX_DATA;
      end
      TX_DATA: begin
        // Payload leaves MSB-first, so the outgoing slice is always the top bits.
        if (w_hs) begin
          pay_d = pay_q << DATA_W;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = TX_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    w_dtype  = FT_BODY;
    flit_out = '0;
    if (cnt_q == LAST_IDX) w_dtype = FT_TAIL;
    case (state_q)
      TX_HEAD: flit_out = make_head(dest_q, src_q);
      TX_DATA: flit_out = make_data(w_dtype, pay_q[PW-1 -: DATA_W]);
      default: flit_out = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      dest_q  <= '0;
      src_q   <= '0;
      pay_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      src_q   <= src_d;
      pay_q   <= pay_d;
      cnt_q   <= cnt_d;
    end
  end

  ni_rx_assembler #(
    .PAYLOAD_FLITS(PAYLOAD_FLITS)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .node_i   (current_node),
    .flit_i   (flit_in),
    .en_i     (flit_in_en),
    .valid_o  (rx_valid),
    .src_o    (rx_src),
    .payload_o(rx_payload),
    .err_o    (rx_err)
  );

endmodule
`default_nettype wire
